// File: rtl/decode_stage_hs.sv
// RV32I/RV32E decode stage: control decode, register file with write-back bypass,
// immediate generation and a valid/ready ID/EX pipeline register with flush.
module decode_stage_hs #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            flush,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            RegWriteE,
   output logic            ALUSrcE,
   output logic            MemWriteE,
   output logic            BranchE,
   output logic            JumpE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic            IllegalE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      RS1E,
   output logic [4:0]      RS2E,
   output logic [4:0]      RDE
);

   localparam int AW = $clog2(NUM_REGS);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_e;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rs1_idx, rs2_idx, rd_idx;

   assign opcode  = InstrD[6:0];
   assign funct3  = InstrD[14:12];
   assign rs1_idx = InstrD[19:15];
   assign rs2_idx = InstrD[24:20];
   assign rd_idx  = InstrD[11:7];

   logic [XLEN-1:0] regs [NUM_REGS];

   // NOTE: the register file is reset explicitly because reset must leave every entry at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (RegWriteW && RDW != 5'd0 && int'(RDW) < NUM_REGS) begin
         regs[RDW[AW-1:0]] <= ResultW;
      end
   end

   // Out-of-range indices (RV32E) and x0 read as zero; a same-cycle write-back wins over the array.
   function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
      read_port = '0;
      if (idx != 5'd0 && int'(idx) < NUM_REGS) begin
         if (RegWriteW && RDW == idx) read_port = ResultW;
         else                         read_port = regs[idx[AW-1:0]];
      end
   endfunction

   logic [XLEN-1:0] rd1, rd2;
   assign rd1 = read_port(rs1_idx);
   assign rd2 = read_port(rs2_idx);

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
   assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
   assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
   assign imm_b = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
   assign imm_j = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

   logic            dec_reg_write, dec_alu_src, dec_mem_write, dec_branch, dec_jump;
   logic            dec_illegal, legal, uses_rs1, uses_rs2, uses_rd;
   logic [1:0]      dec_result_src;
   alu_op_e         dec_alu;
   logic [XLEN-1:0] dec_imm;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      dec_reg_write  = 1'b0;
      dec_alu_src    = 1'b0;
      dec_mem_write  = 1'b0;
      dec_branch     = 1'b0;
      dec_jump       = 1'b0;
      dec_result_src = 2'b00;
      dec_alu        = ALU_ADD;
      dec_imm        = '0;
      legal          = 1'b1;
      uses_rs1       = 1'b0;
      uses_rs2       = 1'b0;
      uses_rd        = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = (opcode == OP_I);
            uses_rs1      = 1'b1;
            uses_rs2      = (opcode == OP_R);
            uses_rd       = 1'b1;
            if (opcode == OP_I) dec_imm = imm_i;
            case (funct3)
               3'b000:  dec_alu = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
               3'b010:  dec_alu = ALU_SLT;
               3'b110:  dec_alu = ALU_OR;
               3'b111:  dec_alu = ALU_AND;
               default: legal   = 1'b0;
            endcase
         end
         OP_LW: begin
            dec_reg_write  = 1'b1;
            dec_alu_src    = 1'b1;
            dec_result_src = 2'b01;
            dec_imm        = imm_i;
            uses_rs1       = 1'b1;
            uses_rd        = 1'b1;
            legal          = (funct3 == 3'b010);
         end
         OP_SW: begin
            dec_mem_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_imm       = imm_s;
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
            legal         = (funct3 == 3'b010);
         end
         OP_BEQ: begin
            dec_branch = 1'b1;
            dec_alu    = ALU_SUB;
            dec_imm    = imm_b;
            uses_rs1   = 1'b1;
            uses_rs2   = 1'b1;
            legal      = (funct3 == 3'b000);
         end
         OP_JAL: begin
            dec_reg_write  = 1'b1;
            dec_jump       = 1'b1;
            dec_result_src = 2'b10;
            dec_imm        = imm_j;
            uses_rd        = 1'b1;
         end
         default: legal = 1'b0;
      endcase

      if ((uses_rs1 && int'(rs1_idx) >= NUM_REGS) ||
          (uses_rs2 && int'(rs2_idx) >= NUM_REGS) ||
          (uses_rd  && int'(rd_idx)  >= NUM_REGS)) legal = 1'b0;

      dec_illegal = !legal;
      if (!legal) begin
         dec_reg_write  = 1'b0;
         dec_alu_src    = 1'b0;
         dec_mem_write  = 1'b0;
         dec_branch     = 1'b0;
         dec_jump       = 1'b0;
         dec_result_src = 2'b00;
         dec_alu        = ALU_ADD;
      end
   end

   assign in_ready = !out_valid || out_ready;

   // Flush outranks load and stall; data fields keep their last value on flush and drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         RegWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         MemWriteE   <= 1'b0;
         BranchE     <= 1'b0;
         JumpE       <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         IllegalE    <= 1'b0;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
         RS1E        <= 5'd0;
         RS2E        <= 5'd0;
         RDE         <= 5'd0;
      end else if (flush) begin
         out_valid <= 1'b0;
         RegWriteE <= 1'b0;
         MemWriteE <= 1'b0;
         BranchE   <= 1'b0;
         JumpE     <= 1'b0;
         IllegalE  <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid   <= 1'b1;
         RegWriteE   <= dec_reg_write;
         ALUSrcE     <= dec_alu_src;
         MemWriteE   <= dec_mem_write;
         BranchE     <= dec_branch;
         JumpE       <= dec_jump;
         ResultSrcE  <= dec_result_src;
         ALUControlE <= dec_alu;
         IllegalE    <= dec_illegal;
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= dec_imm;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         RS1E        <= rs1_idx;
         RS2E        <= rs2_idx;
         RDE         <= rd_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Self-checking bench for decode_stage_hs: directed plan steps, then randomized
// traffic compared against an instruction-level reference model.
module tb_decode_stage_hs;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, RegWriteW, out_ready;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic [4:0]  RDW;

   logic        in_ready, out_valid, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  RS1E, RS2E, RDE;

   logic        e_in_ready, e_out_valid, e_reg_write, e_alu_src, e_mem_write, e_branch, e_jump, e_illegal;
   logic [1:0]  e_result_src;
   logic [2:0]  e_alu_ctl;
   logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
   logic [4:0]  e_rs1, e_rs2, e_rd;

   decode_stage_hs #(.XLEN(32), .NUM_REGS(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .flush(flush), .RegWriteW(RegWriteW), .RDW(RDW),
      .ResultW(ResultW), .out_valid(out_valid), .out_ready(out_ready), .RegWriteE(RegWriteE),
      .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
      .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .IllegalE(IllegalE), .RD1E(RD1E),
      .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1E(RS1E),
      .RS2E(RS2E), .RDE(RDE)
   );

   decode_stage_hs #(.XLEN(32), .NUM_REGS(16)) dut_e (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .flush(flush), .RegWriteW(RegWriteW), .RDW(RDW),
      .ResultW(ResultW), .out_valid(e_out_valid), .out_ready(out_ready), .RegWriteE(e_reg_write),
      .ALUSrcE(e_alu_src), .MemWriteE(e_mem_write), .BranchE(e_branch), .JumpE(e_jump),
      .ResultSrcE(e_result_src), .ALUControlE(e_alu_ctl), .IllegalE(e_illegal), .RD1E(e_rd1),
      .RD2E(e_rd2), .ImmExtE(e_imm), .PCE(e_pc), .PCPlus4E(e_pc4), .RS1E(e_rs1),
      .RS2E(e_rs2), .RDE(e_rd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rw, alusrc, mw, br, jmp, ill;
      logic [1:0]  rsrc;
      logic [2:0]  aluc;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
   } stage_t;

   int          tests = 0;
   int          fails = 0;
   stage_t      m;
   logic        m_valid;
   logic [31:0] mregs [32];
   logic [6:0]  ops  [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
   logic [2:0]  f3s  [4] = '{3'd0, 3'd2, 3'd6, 3'd7};

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic stage_t observed();
      stage_t o;
      o.rw = RegWriteE;  o.alusrc = ALUSrcE; o.mw = MemWriteE; o.br = BranchE;
      o.jmp = JumpE;     o.ill = IllegalE;   o.rsrc = ResultSrcE; o.aluc = ALUControlE;
      o.rd1 = RD1E;      o.rd2 = RD2E;       o.imm = ImmExtE;     o.pc = PCE;
      o.pc4 = PCPlus4E;  o.rs1 = RS1E;       o.rs2 = RS2E;        o.rd = RDE;
      return o;
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (RegWriteW && RDW == idx) return ResultW;
      return mregs[idx];
   endfunction

   // Reference decode: immediates are built as weighted sums of instruction fields.
   function automatic stage_t predict(input logic [31:0] ins);
      stage_t      p     = '0;
      logic [6:0]  op    = ins[6:0];
      logic [2:0]  f3    = ins[14:12];
      logic        legal = 1'b1;
      logic [31:0] hi    = ins[31] ? 32'hFFFF_FFFF : 32'd0;
      p.rs1 = ins[19:15]; p.rs2 = ins[24:20]; p.rd = ins[11:7];
      p.pc = PCD; p.pc4 = PCPlus4D;
      p.rd1 = mread(p.rs1); p.rd2 = mread(p.rs2);
      if (op == 7'h33 || op == 7'h13) begin
         p.rw = 1'b1;
         p.alusrc = (op == 7'h13);
         if (op == 7'h13) p.imm = hi * 4096 + ins[31:20];
         if (f3 == 3'd0)      p.aluc = (op == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
         else if (f3 == 3'd2) p.aluc = 3'd5;
         else if (f3 == 3'd6) p.aluc = 3'd3;
         else if (f3 == 3'd7) p.aluc = 3'd2;
         else legal = 1'b0;
      end else if (op == 7'h03) begin
         p.rw = 1'b1; p.alusrc = 1'b1; p.rsrc = 2'd1;
         p.imm = hi * 4096 + ins[31:20];
         legal = (f3 == 3'd2);
      end else if (op == 7'h23) begin
         p.mw = 1'b1; p.alusrc = 1'b1;
         p.imm = hi * 4096 + ins[31:25] * 32 + ins[11:7];
         legal = (f3 == 3'd2);
      end else if (op == 7'h63) begin
         p.br = 1'b1; p.aluc = 3'd1;
         p.imm = hi * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
         legal = (f3 == 3'd0);
      end else if (op == 7'h6F) begin
         p.rw = 1'b1; p.jmp = 1'b1; p.rsrc = 2'd2;
         p.imm = hi * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
      end else begin
         legal = 1'b0;
      end
      if (!legal) begin
         p.rw = 1'b0; p.alusrc = 1'b0; p.mw = 1'b0; p.br = 1'b0; p.jmp = 1'b0;
         p.rsrc = 2'd0; p.aluc = 3'd0; p.ill = 1'b1;
      end
      return p;
   endfunction

   // One clock: drive inputs, check in_ready, advance the model, compare after the edge.
   task automatic step(input string tag, input logic [31:0] ins, input logic vld, input logic ordy,
                       input logic fl, input logic rw, input logic [4:0] rdw, input logic [31:0] res);
      stage_t nxt;
      logic   nv;
      logic   ir;
      InstrD = ins; PCD = $urandom; PCPlus4D = PCD + 32'd4;
      in_valid = vld; out_ready = ordy; flush = fl;
      RegWriteW = rw; RDW = rdw; ResultW = res;
      #1;
      ir = !m_valid || ordy;
      check({tag, " in_ready"}, in_ready, ir);
      nxt = m; nv = m_valid;
      if (fl) begin
         nv = 1'b0; nxt.rw = 1'b0; nxt.mw = 1'b0; nxt.br = 1'b0; nxt.jmp = 1'b0; nxt.ill = 1'b0;
      end else if (vld && ir) begin
         nxt = predict(ins); nv = 1'b1;
      end else if (ordy) begin
         nv = 1'b0;
      end
      @(posedge clk);
      if (rw && rdw != 5'd0) mregs[rdw] = res;
      m = nxt; m_valid = nv;
      @(negedge clk);
      check({tag, " out_valid"}, out_valid, m_valid);
      check({tag, " fields"}, observed(), m);
   endtask

   task automatic model_clear();
      m = '0; m_valid = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; RegWriteW = 1'b0;
      RDW = 5'd0; ResultW = 32'd0; InstrD = 32'd0; PCD = 32'd0; PCPlus4D = 32'd0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset in_ready", in_ready, 1'b1);
      check("reset out_valid", out_valid, 1'b0);
      check("reset fields", observed(), '0);

      step("addi", 32'h0050_0093, 1, 1, 0, 0, 5'd0, 32'd0);
      check("addi out_valid", out_valid, 1'b1);
      check("addi RegWriteE", RegWriteE, 1'b1);
      check("addi ALUSrcE", ALUSrcE, 1'b1);
      check("addi ImmExtE", ImmExtE, 32'd5);
      check("addi RDE", RDE, 5'd1);
      check("addi ALUControlE", ALUControlE, 3'b000);

      step("sub load", 32'h4020_81B3, 1, 1, 0, 0, 5'd0, 32'd0);
      for (int i = 0; i < 3; i++) step("stall", 32'h0070_0093, 1, 0, 0, 0, 5'd0, 32'd0);
      check("stall in_ready", in_ready, 1'b0);
      check("stall ALUControlE", ALUControlE, 3'b001);
      check("stall RDE", RDE, 5'd3);
      out_ready = 1'b1;
      #1;
      check("release in_ready", in_ready, 1'b1);
      step("drain", 32'h0, 0, 1, 0, 0, 5'd0, 32'd0);

      step("bypass", 32'h0001_0233, 1, 1, 0, 1, 5'd2, 32'hDEAD_BEEF);
      check("bypass RD1E", RD1E, 32'hDEAD_BEEF);
      step("bypass x0", 32'h0000_0233, 1, 1, 0, 1, 5'd0, 32'hDEAD_BEEF);
      check("bypass x0 RD1E", RD1E, 32'd0);

      step("pre-flush", 32'h0050_0093, 1, 1, 0, 0, 5'd0, 32'd0);
      step("flush", 32'hFE53_2E23, 1, 1, 1, 0, 5'd0, 32'd0);
      check("flush out_valid", out_valid, 1'b0);
      check("flush RegWriteE", RegWriteE, 1'b0);
      check("flush MemWriteE", MemWriteE, 1'b0);
      step("post-flush", 32'h0, 0, 1, 0, 0, 5'd0, 32'd0);
      check("post-flush out_valid", out_valid, 1'b0);

      step("sw", 32'hFE53_2E23, 1, 1, 0, 0, 5'd0, 32'd0);
      check("sw ImmExtE", ImmExtE, 32'hFFFF_FFFC);
      check("sw MemWriteE", MemWriteE, 1'b1);
      step("beq", 32'hFE00_0CE3, 1, 1, 0, 0, 5'd0, 32'd0);
      check("beq ImmExtE", ImmExtE, 32'hFFFF_FFF8);
      check("beq BranchE", BranchE, 1'b1);
      step("jal", 32'h0010_00EF, 1, 1, 0, 0, 5'd0, 32'd0);
      check("jal ImmExtE", ImmExtE, 32'h0000_0800);
      check("jal ResultSrcE", ResultSrcE, 2'b10);

      step("illegal", 32'h0000_007F, 1, 1, 0, 0, 5'd0, 32'd0);
      check("illegal IllegalE", IllegalE, 1'b1);
      check("illegal RegWriteE", RegWriteE, 1'b0);
      check("illegal out_valid", out_valid, 1'b1);

      step("rv32e x17", 32'h0010_0893, 1, 1, 0, 0, 5'd0, 32'd0);
      check("rv32e IllegalE", e_illegal, 1'b1);
      check("rv32e RegWriteE", e_reg_write, 1'b0);
      check("rv32e out_valid", e_out_valid, 1'b1);
      check("rv32i x17 IllegalE", IllegalE, 1'b0);

      step("wb x2", 32'h0050_0093, 1, 1, 0, 1, 5'd2, 32'h1234_5678);
      step("stall pre-rst", 32'h0070_0093, 1, 0, 0, 0, 5'd0, 32'd0);
      #2 rst = 1'b1;
      #1;
      model_clear();
      check("mid-stall rst out_valid", out_valid, 1'b0);
      check("mid-stall rst fields", observed(), '0);
      @(negedge clk);
      rst = 1'b0;
      step("post-rst read x2", 32'h0001_0233, 1, 1, 0, 0, 5'd0, 32'd0);
      check("post-rst RD1E", RD1E, 32'd0);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] ins;
         int          k;
         ins = $urandom;
         k   = $urandom_range(0, 6);
         if (k < 6) ins[6:0] = ops[k];
         if ($urandom_range(0, 1) == 1) ins[14:12] = f3s[$urandom_range(0, 3)];
         step("random", ins, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
              $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
